// File: rtl/victim_fill_queue.sv
// Eviction FIFO feeding the victim cache request port; core reads win unless the queue is full. Optional VFQ_DUP_MERGE_EN.
// Latency: a pushed block is issuable the next cycle; evict_valid follows a write issue by EVICT_LAT cycles.
// Backpressure: enq_ready drops on registered full occupancy; rd_stall asserts when a full queue forces a write over a read.
module victim_fill_queue #(
    parameter int DEPTH     = 4,
    parameter int EVICT_LAT = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enq_valid,
    output logic                     enq_ready,
    input  logic [11:0]              enq_page_offset,
    input  logic [43:0]              enq_ptag,
    input  logic [511:0]             enq_data,
    input  logic                     rd_req,
    input  logic [11:0]              rd_page_offset,
    input  logic [43:0]              rd_ptag,
    input  logic                     rd_tlb_miss,
    output logic                     rd_stall,
    output logic [11:0]              vc_page_offset,
    output logic [511:0]             vc_data_in,
    output logic                     vc_write_en,
    output logic [43:0]              vc_phys_tag,
    output logic                     vc_tlb_miss,
    output logic                     evict_valid,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] P2_IDLE = 2'd0;
    localparam logic [1:0] P2_RD   = 2'd1;
    localparam logic [1:0] P2_WR   = 2'd2;

    logic [11:0]          mem_off [DEPTH];
    logic [43:0]          mem_tag [DEPTH];
    logic [511:0]         mem_dat [DEPTH];
    logic [PW-1:0]        head;
    logic [PW-1:0]        tail;
    logic [1:0]           p2_sel;
    logic [43:0]          p2_tag;
    logic [EVICT_LAT-1:0] evict_sr;

    logic          full;
    logic          issue_wr;
    logic          push;
    logic          wr_en;
    logic [PW-1:0] wr_idx;

    always_comb begin
        full     = (count == CW'(DEPTH));
        issue_wr = (count != '0) && (!rd_req || full);
    end

`ifdef VFQ_DUP_MERGE_EN
    logic [PW-1:0] rel [DEPTH];
    logic          match;
    logic [PW-1:0] match_idx;

    // rel is the slot's distance from head; slots closer than count are occupied.
    always_comb begin
        match     = 1'b0;
        match_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            rel[i] = PW'(i) - head;
            if (({1'b0, rel[i]} < count) &&
                (mem_tag[i] == enq_ptag) &&
                (mem_off[i][11:6] == enq_page_offset[11:6]) &&
                !(issue_wr && (PW'(i) == head))) begin
                match     = 1'b1;
                match_idx = PW'(i);
            end
        end
    end

    always_comb begin
        enq_ready = reset && (!full || match);
        wr_en     = enq_valid && enq_ready;
        push      = wr_en && !match;
        wr_idx    = match ? match_idx : tail;
    end
`else
    always_comb begin
        enq_ready = reset && !full;
        push      = enq_valid && enq_ready;
        wr_en     = push;
        wr_idx    = tail;
    end
`endif

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_off[wr_idx] <= enq_page_offset;
            mem_tag[wr_idx] <= enq_ptag;
            mem_dat[wr_idx] <= enq_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            p2_sel   <= P2_IDLE;
            p2_tag   <= '0;
            evict_sr <= '0;
        end else begin
            if (push)
                tail <= tail + 1'b1;
            if (issue_wr) begin
                head   <= head + 1'b1;
                p2_tag <= mem_tag[head];
            end
            count    <= count + CW'(push) - CW'(issue_wr);
            p2_sel   <= issue_wr ? P2_WR : (rd_req ? P2_RD : P2_IDLE);
            evict_sr <= EVICT_LAT'({evict_sr, issue_wr});
        end
    end

    // The victim cache samples tag/TLB-miss one cycle after the request it belongs to.
    always_comb begin
        vc_write_en    = issue_wr;
        vc_page_offset = issue_wr ? mem_off[head] : rd_page_offset;
        vc_data_in     = mem_dat[head];
        rd_stall       = rd_req && issue_wr;
        evict_valid    = evict_sr[EVICT_LAT-1];
        case (p2_sel)
            P2_WR: begin
                vc_phys_tag = p2_tag;
                vc_tlb_miss = 1'b0;
            end
            P2_RD: begin
                vc_phys_tag = rd_ptag;
                vc_tlb_miss = rd_tlb_miss;
            end
            default: begin
                vc_phys_tag = '0;
                vc_tlb_miss = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_victim_fill_queue.sv
module tb_victim_fill_queue;
    logic         clk = 1'b0;
    logic         reset;
    logic         enq_valid;
    logic         enq_ready;
    logic [11:0]  enq_page_offset;
    logic [43:0]  enq_ptag;
    logic [511:0] enq_data;
    logic         rd_req;
    logic [11:0]  rd_page_offset;
    logic [43:0]  rd_ptag;
    logic         rd_tlb_miss;
    logic         rd_stall;
    logic [11:0]  vc_page_offset;
    logic [511:0] vc_data_in;
    logic         vc_write_en;
    logic [43:0]  vc_phys_tag;
    logic         vc_tlb_miss;
    logic         evict_valid;
    logic [2:0]   count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    victim_fill_queue #(.DEPTH(4), .EVICT_LAT(3)) dut (
        .clk(clk), .reset(reset),
        .enq_valid(enq_valid), .enq_ready(enq_ready),
        .enq_page_offset(enq_page_offset), .enq_ptag(enq_ptag), .enq_data(enq_data),
        .rd_req(rd_req), .rd_page_offset(rd_page_offset), .rd_ptag(rd_ptag),
        .rd_tlb_miss(rd_tlb_miss), .rd_stall(rd_stall),
        .vc_page_offset(vc_page_offset), .vc_data_in(vc_data_in),
        .vc_write_en(vc_write_en), .vc_phys_tag(vc_phys_tag), .vc_tlb_miss(vc_tlb_miss),
        .evict_valid(evict_valid), .count(count)
    );

    task automatic check(input string tag, input logic [511:0] act, input logic [511:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [511:0] pat(input int k);
        logic [31:0] w;
        w   = 32'(k) * 32'h9E37_79B9;
        pat = {16{w}};
    endfunction

    task automatic enq(input logic [43:0] tag, input logic [11:0] off, input logic [511:0] dat);
        enq_valid       = 1'b1;
        enq_ptag        = tag;
        enq_page_offset = off;
        enq_data        = dat;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; enq_valid = 1'b1; enq_page_offset = '0; enq_ptag = '0; enq_data = '0;
        rd_req = 1'b1; rd_page_offset = '0; rd_ptag = 44'h5A5; rd_tlb_miss = 1'b1;

        // in reset
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            check("rst_count", 512'(count), 512'(0));
            check("rst_enq_ready", 512'(enq_ready), 512'(0));
            check("rst_write_en", 512'(vc_write_en), 512'(0));
            check("rst_evict", 512'(evict_valid), 512'(0));
            check("rst_phys_tag", 512'(vc_phys_tag), 512'(0));
            check("rst_tlb_miss", 512'(vc_tlb_miss), 512'(0));
            check("rst_stall", 512'(rd_stall), 512'(0));
        end

        // after release, idle
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) begin
                reset = 1'b1; rd_req = 1'b0; enq_valid = 1'b0; rd_tlb_miss = 1'b0; rd_ptag = '0;
            end
            #1;
            check("idle_count", 512'(count), 512'(0));
            check("idle_enq_ready", 512'(enq_ready), 512'(1));
            check("idle_write_en", 512'(vc_write_en), 512'(0));
            check("idle_evict", 512'(evict_valid), 512'(0));
        end

        // single entry, no reads
        @(negedge clk); enq(44'h123, 12'h0C0, pat(1)); #1;
        check("s1_enq_ready", 512'(enq_ready), 512'(1));
        check("s1_no_bypass", 512'(vc_write_en), 512'(0));
        @(negedge clk); enq_valid = 1'b0; #1;
        check("s1_count", 512'(count), 512'(1));
        check("s1_write_en", 512'(vc_write_en), 512'(1));
        check("s1_offset", 512'(vc_page_offset), 512'(12'h0C0));
        check("s1_data", vc_data_in, pat(1));
        check("s1_stall", 512'(rd_stall), 512'(0));
        @(negedge clk); rd_ptag = 44'h999; rd_tlb_miss = 1'b1; #1;
        check("s1_phys_tag", 512'(vc_phys_tag), 512'(44'h123));
        check("s1_tlb_miss", 512'(vc_tlb_miss), 512'(0));
        check("s1_count_drain", 512'(count), 512'(0));
        check("s1_write_done", 512'(vc_write_en), 512'(0));
        check("s1_evict_t1", 512'(evict_valid), 512'(0));
        @(negedge clk); rd_ptag = '0; rd_tlb_miss = 1'b0; #1;
        check("s1_evict_t2", 512'(evict_valid), 512'(0));
        @(negedge clk); #1;
        check("s1_evict_t3", 512'(evict_valid), 512'(1));
        @(negedge clk); #1;
        check("s1_evict_t4", 512'(evict_valid), 512'(0));

        // reads held while enqueueing
        @(negedge clk); rd_req = 1'b1; rd_page_offset = 12'h3A4; enq(44'h200, 12'h140, pat(2)); #1;
        check("rd0_offset", 512'(vc_page_offset), 512'(12'h3A4));
        check("rd0_write_en", 512'(vc_write_en), 512'(0));
        check("rd0_stall", 512'(rd_stall), 512'(0));
        @(negedge clk); rd_page_offset = 12'h7FF; rd_ptag = 44'hABC; rd_tlb_miss = 1'b1;
        enq(44'h201, 12'h180, pat(3)); #1;
        check("rd1_count", 512'(count), 512'(1));
        check("rd1_write_en", 512'(vc_write_en), 512'(0));
        check("rd1_stall", 512'(rd_stall), 512'(0));
        check("rd1_offset", 512'(vc_page_offset), 512'(12'h7FF));
        check("rd1_phys_tag", 512'(vc_phys_tag), 512'(44'hABC));
        check("rd1_tlb_miss", 512'(vc_tlb_miss), 512'(1));
        @(negedge clk); enq_valid = 1'b0; rd_page_offset = 12'h010; rd_ptag = 44'hDEF; rd_tlb_miss = 1'b0; #1;
        check("rd2_count", 512'(count), 512'(2));
        check("rd2_phys_tag", 512'(vc_phys_tag), 512'(44'hDEF));
        check("rd2_tlb_miss", 512'(vc_tlb_miss), 512'(0));
        check("rd2_write_en", 512'(vc_write_en), 512'(0));

        // fill to full under reads
        @(negedge clk); enq(44'h202, 12'h1C0, pat(4)); #1;
        check("f3_count", 512'(count), 512'(2));
        @(negedge clk); enq(44'h203, 12'h200, pat(5)); #1;
        check("f4_count", 512'(count), 512'(3));
        check("f4_enq_ready", 512'(enq_ready), 512'(1));
        check("f4_stall", 512'(rd_stall), 512'(0));
        @(negedge clk); enq(44'h204, 12'h240, pat(6)); #1;
        check("full_count", 512'(count), 512'(4));
        check("full_enq_ready", 512'(enq_ready), 512'(0));
        check("full_stall", 512'(rd_stall), 512'(1));
        check("full_write_en", 512'(vc_write_en), 512'(1));
        check("full_offset", 512'(vc_page_offset), 512'(12'h140));
        check("full_data", vc_data_in, pat(2));
        @(negedge clk); enq_valid = 1'b0; rd_ptag = 44'hABC; rd_tlb_miss = 1'b1; #1;
        check("after_full_count", 512'(count), 512'(3));
        check("after_full_ready", 512'(enq_ready), 512'(1));
        check("after_full_stall", 512'(rd_stall), 512'(0));
        check("after_full_write", 512'(vc_write_en), 512'(0));
        check("after_full_tag", 512'(vc_phys_tag), 512'(44'h200));
        check("after_full_tlb", 512'(vc_tlb_miss), 512'(0));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); rd_req = 1'b0; rd_tlb_miss = 1'b0; #1;
            check("drain_write_en", 512'(vc_write_en), 512'(1));
            check("drain_offset", 512'(vc_page_offset), 512'(12'h180 + 12'(k * 64)));
            check("drain_data", vc_data_in, pat(3 + k));
            check("drain_count", 512'(count), 512'(3 - k));
        end
        @(negedge clk); #1;
        check("drain_empty", 512'(count), 512'(0));
        check("drain_idle", 512'(vc_write_en), 512'(0));
        repeat (4) @(negedge clk);

        // interleaved push/pop across pointer wrap
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            if (k < 6) enq(44'h300 + 44'(k), 12'(k * 64 + 4), pat(10 + k));
            else enq_valid = 1'b0;
            #1;
            if (k >= 1 && k <= 6) begin
                check("wrap_write_en", 512'(vc_write_en), 512'(1));
                check("wrap_offset", 512'(vc_page_offset), 512'(12'((k - 1) * 64 + 4)));
                check("wrap_data", vc_data_in, pat(9 + k));
                check("wrap_count", 512'(count), 512'(1));
            end else begin
                check("wrap_idle", 512'(vc_write_en), 512'(0));
                check("wrap_empty", 512'(count), 512'(0));
            end
            check("wrap_evict", 512'(evict_valid), 512'(k >= 4 && k <= 9));
        end

        // same tag/index enqueued twice before issue
        @(negedge clk); rd_req = 1'b1; rd_page_offset = '0; enq(44'h55, 12'h0C0, pat(20)); #1;
        check("dup0_ready", 512'(enq_ready), 512'(1));
        @(negedge clk); enq(44'h55, 12'h0C4, pat(21)); #1;
        check("dup1_ready", 512'(enq_ready), 512'(1));
        check("dup1_count", 512'(count), 512'(1));
        @(negedge clk); enq_valid = 1'b0; rd_req = 1'b0; #1;
        check("dup2_write_en", 512'(vc_write_en), 512'(1));
`ifdef VFQ_DUP_MERGE_EN
        check("dup2_count", 512'(count), 512'(1));
        check("dup2_data", vc_data_in, pat(21));
        check("dup2_offset", 512'(vc_page_offset), 512'(12'h0C4));
        @(negedge clk); #1;
        check("dup3_write_en", 512'(vc_write_en), 512'(0));
        check("dup3_count", 512'(count), 512'(0));
`else
        check("dup2_count", 512'(count), 512'(2));
        check("dup2_data", vc_data_in, pat(20));
        check("dup2_offset", 512'(vc_page_offset), 512'(12'h0C0));
        @(negedge clk); #1;
        check("dup3_write_en", 512'(vc_write_en), 512'(1));
        check("dup3_data", vc_data_in, pat(21));
        check("dup3_count", 512'(count), 512'(1));
`endif
        repeat (4) @(negedge clk);

        // reset mid-flight drops queued entry and pending evict
        @(negedge clk); enq(44'h77, 12'h000, pat(30)); #1;
        @(negedge clk); enq(44'h78, 12'h040, pat(31)); #1;
        check("mr_issue", 512'(vc_write_en), 512'(1));
        @(negedge clk); enq_valid = 1'b0; #2; reset = 1'b0; #1;
        check("mr_count", 512'(count), 512'(0));
        check("mr_enq_ready", 512'(enq_ready), 512'(0));
        check("mr_phys_tag", 512'(vc_phys_tag), 512'(0));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            check("mr_evict", 512'(evict_valid), 512'(0));
        end
        @(negedge clk); reset = 1'b1; #1;
        check("mr_rel_count", 512'(count), 512'(0));
        check("mr_rel_write", 512'(vc_write_en), 512'(0));
        check("mr_rel_ready", 512'(enq_ready), 512'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
